vga_text_fetch_arbiter: RTL

Owns the single-port text buffer RAM of the VGA text-mode path and shares it between display character fetch and CPU accesses. It sits between the VGA timing generator (disp/x_pos/y_pos) and the glyph/font stage. It issues one character fetch per 8-pixel cell during active display, and fits CPU read/write requests into the remaining cycles through a valid/ready handshake.

---
 rtl/vga_text_fetch_arbiter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/vga_text_fetch_arbiter.sv
// Text buffer RAM arbiter: one display fetch per character cell, CPU accesses in the gaps.
// Optional blinking cursor built when VGA_TEXT_CURSOR_EN is defined.
module vga_text_fetch_arbiter #(
  parameter int unsigned CHAR_W       = 8,
  parameter int unsigned CHAR_H       = 16,
  parameter int unsigned COLS         = 160,
  parameter int unsigned ROWS         = 64,
  parameter int unsigned X_WIDTH      = 11,
  parameter int unsigned Y_WIDTH      = 10,
  parameter int unsigned ADDR_WIDTH   = $clog2(COLS*ROWS),
  parameter int unsigned BLINK_FRAMES = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        disp_in,
  input  logic [X_WIDTH-1:0]          x_pos,
  input  logic [Y_WIDTH-1:0]          y_pos,
  output logic [ADDR_WIDTH-1:0]       ram_addr,
  output logic                        ram_we,
  output logic [7:0]                  ram_wdata,
  input  logic [7:0]                  ram_rdata,
  input  logic                        cpu_req_valid,
  output logic                        cpu_req_ready,
  input  logic                        cpu_req_we,
  input  logic [ADDR_WIDTH-1:0]       cpu_req_addr,
  input  logic [7:0]                  cpu_req_wdata,
  output logic                        cpu_rsp_valid,
  output logic [7:0]                  cpu_rsp_data,
  output logic                        char_valid,
  output logic [7:0]                  char_code,
  output logic [$clog2(CHAR_H)-1:0]   char_row,
  output logic [$clog2(COLS)-1:0]     char_col,
  input  logic [ADDR_WIDTH-1:0]       cursor_addr,
  output logic                        char_cursor
);

  localparam int unsigned XS    = $clog2(CHAR_W);
  localparam int unsigned YS    = $clog2(CHAR_H);
  localparam int unsigned COL_W = $clog2(COLS);
  localparam int unsigned CELLS = COLS * ROWS;

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_WAIT, S_RESP} cpu_state_t;

  cpu_state_t state, state_nxt;
  logic       wait_cnt, wait_cnt_nxt;
  logic       accept_c, issue_c, slot_c, cur_hit_c;
  logic [ADDR_WIDTH-1:0] slot_addr_c;

  logic                  req_we, req_oob;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [7:0]            req_wdata;

  logic             s1_valid, s2_valid, s1_cur, s2_cur;
  logic [YS-1:0]    s1_row, s2_row;
  logic [COL_W-1:0] s1_col, s2_col;

  assign slot_c      = disp_in && (x_pos[XS-1:0] == '0);
  assign slot_addr_c = ADDR_WIDTH'((32'(y_pos) >> YS) * COLS + (32'(x_pos) >> XS));

`ifdef VGA_TEXT_CURSOR_EN
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic          disp_q, blink_on;
  logic [FW-1:0] frame_cnt;

  // Frame starts are rising edges of disp_in on the top line.
  always_ff @(posedge clk) begin
    if (reset) begin
      disp_q    <= 1'b0;
      frame_cnt <= '0;
      blink_on  <= 1'b1;
    end else begin
      disp_q <= disp_in;
      if (disp_in && !disp_q && (y_pos == '0)) begin
        if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
          frame_cnt <= '0;
          blink_on  <= ~blink_on;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end
    end
  end

  assign cur_hit_c = blink_on && (slot_addr_c == cursor_addr);
`else
  logic unused_cursor;
  assign unused_cursor = ^cursor_addr;
  assign cur_hit_c     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      wait_cnt <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // CPU access sequencing; display slots always take the RAM first.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    accept_c     = 1'b0;
    issue_c      = 1'b0;
    case (state)
      S_IDLE: if (cpu_req_valid) begin
        accept_c  = 1'b1;
        state_nxt = S_PEND;
      end
      S_PEND: if (!slot_c) begin
        issue_c      = 1'b1;
        wait_cnt_nxt = 1'b0;
        state_nxt    = S_WAIT;
      end
      S_WAIT: if (wait_cnt) state_nxt = S_RESP;
              else          wait_cnt_nxt = 1'b1;
      S_RESP: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_req_ready <= 1'b1;
      cpu_rsp_valid <= 1'b0;
      cpu_rsp_data  <= '0;
      req_we        <= 1'b0;
      req_oob       <= 1'b0;
      req_addr      <= '0;
      req_wdata     <= '0;
      ram_addr      <= '0;
      ram_we        <= 1'b0;
      ram_wdata     <= '0;
      s1_valid      <= 1'b0;
      s1_cur        <= 1'b0;
      s1_row        <= '0;
      s1_col        <= '0;
      s2_valid      <= 1'b0;
      s2_cur        <= 1'b0;
      s2_row        <= '0;
      s2_col        <= '0;
      char_valid    <= 1'b0;
      char_code     <= '0;
      char_row      <= '0;
      char_col      <= '0;
      char_cursor   <= 1'b0;
    end else begin
      cpu_req_ready <= (state_nxt == S_IDLE);
      cpu_rsp_valid <= (state_nxt == S_RESP);
      // Read data arrives two cycles after issue, i.e. in the last WAIT cycle.
      cpu_rsp_data  <= (state == S_WAIT && wait_cnt && !req_we && !req_oob) ? ram_rdata : 8'h00;

      if (accept_c) begin
        req_we    <= cpu_req_we;
        req_oob   <= 32'(cpu_req_addr) >= CELLS;
        req_addr  <= cpu_req_addr;
        req_wdata <= cpu_req_wdata;
      end

      if (slot_c) begin
        ram_addr <= slot_addr_c;
        ram_we   <= 1'b0;
      end else if (issue_c) begin
        ram_addr <= req_addr;
        ram_we   <= req_we && !req_oob;
        if (req_we) ram_wdata <= req_wdata;
      end else begin
        ram_we <= 1'b0;
      end

      s1_valid <= slot_c;
      s1_cur   <= cur_hit_c;
      s1_row   <= y_pos[YS-1:0];
      s1_col   <= COL_W'(x_pos >> XS);
      s2_valid <= s1_valid;
      s2_cur   <= s1_cur;
      s2_row   <= s1_row;
      s2_col   <= s1_col;

      char_valid  <= s2_valid;
      char_cursor <= s2_valid && s2_cur;
      if (s2_valid) begin
        char_code <= ram_rdata;
        char_row  <= s2_row;
        char_col  <= s2_col;
      end
    end
  end

endmodule
